// File: rtl/cfg_chain_shifter_if.sv
// Word-stream bundle between the firmware side and the configuration chain shifter.
// s_w* carries chain image words into the shifter; m_r* carries readback words out.
interface cfg_chain_shifter_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_wdata;
  logic              s_wvalid;
  logic              s_wready;
  logic [WORD_W-1:0] m_rdata;
  logic              m_rvalid;
  logic              m_rready;

  // Firmware side: produces image words, consumes readback words.
  modport master (
    output s_wdata, s_wvalid, m_rready,
    input  s_wready, m_rdata, m_rvalid
  );

  // Shifter side: consumes image words, produces readback words.
  modport slave (
    input  s_wdata, s_wvalid, m_rready,
    output s_wready, m_rdata, m_rvalid
  );
endinterface

// File: rtl/cfg_chain_shifter.sv
// Configuration scan-chain driver for the CMS pixel test chip.
// Takes the chain image as WORD_W-bit words, shifts it out LSB-first on a
// programmable-rate config_clk, pulses config_load, and packs the bits that
// come back on config_out into readback words.
module cfg_chain_shifter #(
  parameter int CHAIN_LEN = 768,
  parameter int WORD_W    = 32,
  parameter int DIV_W     = 16
) (
  input  logic             pl_clk1,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] clk_half_period,
  output logic             busy,
  output logic             done,
  cfg_chain_shifter_if.slave bus,
  output logic             config_clk,
  output logic             config_in,
  output logic             config_load,
  input  logic             config_out
);

  localparam int TW = $clog2(CHAIN_LEN + 1);  // total bit counter width
  localparam int BW = $clog2(WORD_W + 1);     // bit-in-word counter width
  localparam int CW = DIV_W + 1;              // phase timer, must reach 2*H-1

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    LOAD  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  h_q;
  logic [CW-1:0]     tick;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     total_cnt;
  logic [WORD_W-1:0] word_sr, word_d;
  logic [WORD_W-1:0] rb_sr, rb_next;
  logic [WORD_W-1:0] m_rdata_q;
  logic              m_rvalid_q;

  logic [CW-1:0]     h_last, load_last;
  logic              last_bit, word_end, push_need, stall, push;
  logic              start_ok, accept, sample, bit_adv, tick_inc;

  // Phase end points: LO/HI last H cycles, LOAD lasts 2*H cycles.
  assign h_last    = {1'b0, h_q} - CW'(1);
  assign load_last = {h_q, 1'b0} - CW'(1);

  assign last_bit  = (total_cnt == TW'(CHAIN_LEN - 1));
  assign word_end  = (bit_cnt == BW'(WORD_W - 1));
  // A readback word is complete when its last bit or the chain's last bit is sampled.
  assign push_need = word_end || last_bit;
  // The output slot is still occupied and not being drained: freeze in place.
  assign stall     = push_need && m_rvalid_q && !bus.m_rready;
  assign push      = sample && push_need;
  assign rb_next   = rb_sr | (WORD_W'(config_out) << bit_cnt);

  assign busy         = (state != IDLE);
  assign bus.s_wready = (state == FETCH);
  assign bus.m_rdata  = m_rdata_q;
  assign bus.m_rvalid = m_rvalid_q;

  // Next-state and per-cycle strobes for the shift sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state;
    word_d   = word_sr;
    start_ok = 1'b0;
    accept   = 1'b0;
    sample   = 1'b0;
    bit_adv  = 1'b0;
    tick_inc = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (bus.s_wvalid) begin
          accept  = 1'b1;
          word_d  = bus.s_wdata;
          state_d = LO;
        end
      end
      LO: begin
        if (tick != h_last) begin
          tick_inc = 1'b1;
        end else if (!stall) begin
          sample  = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        if (tick != h_last) begin
          tick_inc = 1'b1;
        end else begin
          bit_adv = 1'b1;
          word_d  = word_sr >> 1;
          if (last_bit)      state_d = LOAD;
          else if (word_end) state_d = FETCH;
          else               state_d = LO;
        end
      end
      LOAD: begin
        if (tick != load_last) tick_inc = 1'b1;
        else                   state_d  = DRAIN;
      end
      DRAIN: begin
        if (!m_rvalid_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, phase timer, registered pin drivers and readback slot.
  always_ff @(posedge pl_clk1) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      tick        <= '0;
      config_clk  <= 1'b0;
      config_in   <= 1'b0;
      config_load <= 1'b0;
      m_rvalid_q  <= 1'b0;
      m_rdata_q   <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) tick <= '0;
      else if (tick_inc)    tick <= tick + CW'(1);
      // Pins are driven from flops so config_clk never glitches on state decode.
      config_clk  <= (state_d == HI);
      config_load <= (state_d == LOAD);
      config_in   <= ((state_d == LO) || (state_d == HI)) && word_d[0];
      if (m_rvalid_q && bus.m_rready) m_rvalid_q <= 1'b0;
      if (push) begin
        m_rvalid_q <= 1'b1;
        m_rdata_q  <= rb_next;
      end
    end
  end

  // Datapath registers: rate latch, word shifter, bit counters, readback packer.
  always_ff @(posedge pl_clk1) begin
    // NOTE: no reset here; every register is re-initialised when a transfer starts or a word is fetched.
    if (start_ok) begin
      h_q       <= (clk_half_period == '0) ? DIV_W'(1) : clk_half_period;
      total_cnt <= '0;
      rb_sr     <= '0;
    end
    word_sr <= word_d;
    if (accept) bit_cnt <= '0;
    if (bit_adv) begin
      bit_cnt   <= bit_cnt + BW'(1);
      total_cnt <= total_cnt + TW'(1);
    end
    if (sample) rb_sr <= push ? '0 : rb_next;
  end

endmodule

// File: tb/tb_cfg_chain_shifter.sv
// Directed bench for cfg_chain_shifter with a 40-bit model of the DUT's scan chain.
module tb_cfg_chain_shifter;
  localparam int CHAIN_LEN = 40;
  localparam int WORD_W    = 32;
  localparam int DIV_W     = 16;

  logic             pl_clk1 = 1'b0;
  logic             reset   = 1'b1;
  logic             start   = 1'b0;
  logic [DIV_W-1:0] clk_half_period = 16'd2;
  logic             busy, done, config_clk, config_in, config_load, config_out;

  cfg_chain_shifter_if #(.WORD_W(WORD_W)) bus ();

  cfg_chain_shifter #(
    .CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .DIV_W(DIV_W)
  ) dut (
    .pl_clk1        (pl_clk1),
    .reset          (reset),
    .start          (start),
    .clk_half_period(clk_half_period),
    .busy           (busy),
    .done           (done),
    .bus            (bus),
    .config_clk     (config_clk),
    .config_in      (config_in),
    .config_load    (config_load),
    .config_out     (config_out)
  );

  always #5 pl_clk1 = ~pl_clk1;

  // Chain model and event monitors.
  logic [CHAIN_LEN-1:0] model_sr = '0;
  logic [CHAIN_LEN-1:0] model_lat = '0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 preload = 1'b0;
  logic                 clk_prev = 1'b0;
  int                   cyc = 0, rise_cnt = 0, rise_last = 0, rise_prev = 0;
  int                   load_cnt = 0, done_cnt = 0, rb_n = 0;
  logic [WORD_W-1:0]    rb_mem [0:63];
  int                   n_cmp = 0, n_fail = 0;

  assign config_out = model_sr[0];

  // Shift on each config_clk rising edge, latch on config_load, collect readback.
  always @(posedge pl_clk1) begin
    cyc      <= cyc + 1;
    clk_prev <= config_clk;
    if (preload) begin
      model_sr <= preload_val;
    end else if (config_clk === 1'b1 && clk_prev === 1'b0) begin
      model_sr  <= {config_in, model_sr[CHAIN_LEN-1:1]};
      rise_cnt  <= rise_cnt + 1;
      rise_prev <= rise_last;
      rise_last <= cyc;
    end
    if (config_load === 1'b1) begin
      model_lat <= model_sr;
      load_cnt  <= load_cnt + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.m_rvalid === 1'b1 && bus.m_rready === 1'b1 && rb_n < 64) begin
      rb_mem[rb_n] <= bus.m_rdata;
      rb_n         <= rb_n + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pl_clk1);
  endtask

  task automatic preload_model(input logic [CHAIN_LEN-1:0] v);
    preload_val = v;
    preload     = 1'b1;
    tick(1);
    preload     = 1'b0;
  endtask

  task automatic start_xfer(input logic [DIV_W-1:0] h);
    clk_half_period = h;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input string tag);
    int n = 0;
    bus.s_wdata  = d;
    bus.s_wvalid = 1'b1;
    while (bus.s_wready !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, "_accept"}, 64'(bus.s_wready), 64'd1);
    tick(1);
    bus.s_wvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    tick(1);
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (rise_cnt < target && n < 5000) begin
      tick(1);
      n++;
    end
    check({tag, "_rises_reached"}, 64'(rise_cnt >= target), 64'd1);
  endtask

  // Full transfer of two words; checks image, readback, edge and load counts.
  task automatic transfer(input logic [DIV_W-1:0] h, input logic [WORD_W-1:0] w0,
                          input logic [WORD_W-1:0] w1, input logic [CHAIN_LEN-1:0] exp_img,
                          input logic [WORD_W-1:0] exp_rb0, input logic [WORD_W-1:0] exp_rb1,
                          input int exp_loads, input string tag);
    int r0 = rise_cnt, l0 = load_cnt, d0 = done_cnt, b0 = rb_n;
    start_xfer(h);
    send_word(w0, {tag, "_w0"});
    send_word(w1, {tag, "_w1"});
    wait_done(tag);
    check({tag, "_image"},  64'(model_lat), 64'(exp_img));
    check({tag, "_rises"},  64'(rise_cnt - r0), 64'd40);
    check({tag, "_loads"},  64'(load_cnt - l0), 64'(exp_loads));
    check({tag, "_dones"},  64'(done_cnt - d0), 64'd1);
    check({tag, "_rbn"},    64'(rb_n - b0), 64'd2);
    check({tag, "_rb0"},    64'(rb_mem[b0]), 64'(exp_rb0));
    check({tag, "_rb1"},    64'(rb_mem[b0 + 1]), 64'(exp_rb1));
    check({tag, "_idle"},   64'(busy), 64'd0);
  endtask

  initial begin
    int r0, b0, d0, n;
    bus.s_wdata  = '0;
    bus.s_wvalid = 1'b0;
    bus.m_rready = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state of every output.
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_cclk",  64'(config_clk), 64'd0);
    check("rst_cin",   64'(config_in), 64'd0);
    check("rst_cload", 64'(config_load), 64'd0);
    check("rst_wrdy",  64'(bus.s_wready), 64'd0);
    check("rst_rvld",  64'(bus.m_rvalid), 64'd0);
    check("rst_rdata", 64'(bus.m_rdata), 64'd0);

    // Basic transfer, H=2; unused high bits of the last word are ignored.
    preload_model(40'h12_3456_789A);
    r0 = rise_cnt;
    start_xfer(16'd2);
    check("t1_busy", 64'(busy), 64'd1);
    send_word(32'hDEAD_BEEF, "t1_w0");
    wait_rises(r0 + 3, "t1_per");
    check("t1_period", 64'(rise_last - rise_prev), 64'd4);
    send_word(32'hFFFF_FFA5, "t1_w1");
    wait_done("t1");
    check("t1_image", 64'(model_lat), 64'h00A5_DEAD_BEEF);
    check("t1_rises", 64'(rise_cnt - r0), 64'd40);
    check("t1_loads", 64'(load_cnt), 64'd4);
    check("t1_rb0",   64'(rb_mem[0]), 64'h3456_789A);
    check("t1_rb1",   64'(rb_mem[1]), 64'h0000_0012);
    check("t1_rbn",   64'(rb_n), 64'd2);

    // Back-to-back: the second transfer reads back the first image.
    preload_model('0);
    transfer(16'd2, 32'hDEAD_BEEF, 32'h0000_00A5, 40'hA5_DEAD_BEEF,
             32'h0, 32'h0, 4, "t2a");
    transfer(16'd2, 32'h1122_3344, 32'h0000_0055, 40'h55_1122_3344,
             32'hDEAD_BEEF, 32'h0000_00A5, 4, "t2b");

    // clk_half_period = 0 acts as 1: config_clk period 2.
    r0 = rise_cnt; b0 = rb_n;
    start_xfer(16'd0);
    send_word(32'h0F0F_0F0F, "t3a_w0");
    wait_rises(r0 + 3, "t3a_per");
    check("t3a_period", 64'(rise_last - rise_prev), 64'd2);
    send_word(32'h0000_00F0, "t3a_w1");
    wait_done("t3a");
    check("t3a_image", 64'(model_lat), 64'hF0_0F0F_0F0F);
    check("t3a_rb0",   64'(rb_mem[b0]), 64'h1122_3344);
    check("t3a_rb1",   64'(rb_mem[b0 + 1]), 64'h0000_0055);

    // H=5, then change the input mid-transfer: period stays 10.
    r0 = rise_cnt; b0 = rb_n; n = load_cnt;
    start_xfer(16'd5);
    clk_half_period = 16'd1;
    send_word(32'h0123_4567, "t3b_w0");
    wait_rises(r0 + 3, "t3b_per");
    check("t3b_period", 64'(rise_last - rise_prev), 64'd10);
    send_word(32'h0000_0089, "t3b_w1");
    wait_rises(r0 + 38, "t3b_per2");
    check("t3b_period2", 64'(rise_last - rise_prev), 64'd10);
    wait_done("t3b");
    check("t3b_image", 64'(model_lat), 64'h89_0123_4567);
    check("t3b_loads", 64'(load_cnt - n), 64'd10);
    check("t3b_rb0",   64'(rb_mem[b0]), 64'h0F0F_0F0F);
    check("t3b_rb1",   64'(rb_mem[b0 + 1]), 64'h0000_00F0);

    // Readback backpressure: the shifter freezes before the final sample.
    preload_model(40'hC3_0F0F_1234);
    bus.m_rready = 1'b0;
    r0 = rise_cnt; b0 = rb_n;
    start_xfer(16'd2);
    send_word(32'hAAAA_5555, "t4_w0");
    send_word(32'h0000_003C, "t4_w1");
    tick(50);
    check("t4_frozen_rises", 64'(rise_cnt - r0), 64'd39);
    check("t4_frozen_cclk",  64'(config_clk), 64'd0);
    check("t4_rvalid",       64'(bus.m_rvalid), 64'd1);
    check("t4_rdata",        64'(bus.m_rdata), 64'h0F0F_1234);
    check("t4_busy",         64'(busy), 64'd1);
    tick(20);
    check("t4_still_frozen", 64'(rise_cnt - r0), 64'd39);
    bus.m_rready = 1'b1;
    wait_done("t4");
    check("t4_image", 64'(model_lat), 64'h3C_AAAA_5555);
    check("t4_rises", 64'(rise_cnt - r0), 64'd40);
    check("t4_rb0",   64'(rb_mem[b0]), 64'h0F0F_1234);
    check("t4_rb1",   64'(rb_mem[b0 + 1]), 64'h0000_00C3);

    // Input starvation between words: config_clk parked low.
    preload_model(40'h66_7788_99AA);
    r0 = rise_cnt; b0 = rb_n;
    start_xfer(16'd2);
    send_word(32'h1357_9BDF, "t5_w0");
    n = 0;
    while (bus.s_wready !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(20);
    check("t5_starve_rises", 64'(rise_cnt - r0), 64'd32);
    check("t5_starve_cclk",  64'(config_clk), 64'd0);
    check("t5_starve_wrdy",  64'(bus.s_wready), 64'd1);
    send_word(32'h0000_00E7, "t5_w1");
    wait_done("t5");
    check("t5_image", 64'(model_lat), 64'hE7_1357_9BDF);
    check("t5_rb0",   64'(rb_mem[b0]), 64'h7788_99AA);
    check("t5_rb1",   64'(rb_mem[b0 + 1]), 64'h0000_0066);

    // Reset during bit 17, then a clean transfer.
    r0 = rise_cnt; d0 = done_cnt;
    start_xfer(16'd2);
    send_word(32'h0BAD_F00D, "t6_w0");
    wait_rises(r0 + 17, "t6_bit17");
    reset = 1'b1;
    tick(1);
    check("t6_busy",  64'(busy), 64'd0);
    check("t6_cclk",  64'(config_clk), 64'd0);
    check("t6_cin",   64'(config_in), 64'd0);
    check("t6_cload", 64'(config_load), 64'd0);
    check("t6_wrdy",  64'(bus.s_wready), 64'd0);
    check("t6_rvld",  64'(bus.m_rvalid), 64'd0);
    check("t6_rdata", 64'(bus.m_rdata), 64'd0);
    check("t6_done",  64'(done), 64'd0);
    reset = 1'b0;
    tick(3);
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    preload_model(40'h5A_C0FF_EE00);
    transfer(16'd3, 32'h89AB_CDEF, 32'h0000_003C, 40'h3C_89AB_CDEF,
             32'hC0FF_EE00, 32'h0000_005A, 6, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_chain_shifter.md
Name: cfg_chain_shifter

Overview:
Drives the CMS pixel 28 DUT configuration scan chain (config_clk, config_in, config_load) on the DUT-side clock domain, and captures config_out readback.
Sits between the AXI register bank / word FIFO inside fw_top and the FPGA pins.
Accepts the chain image as a stream of WORD_W-bit words, shifts it LSB-first with a programmable config_clk rate, pulses config_load, and returns the shifted-out bits as words.

Parameters:
CHAIN_LEN, 768, total configuration chain length in bits (>= 1).
WORD_W, 32, width of the input and readback word streams.
DIV_W, 16, width of the clk_half_period control input.

Ports:
pl_clk1  in  1  DUT-side clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin a full chain transfer.
clk_half_period  in  DIV_W  config_clk half-period in pl_clk1 cycles; 0 is treated as 1.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when the transfer completes.
s_wdata  in  WORD_W  next chain word; bit 0 is shifted first.
s_wvalid  in  1  s_wdata valid.
s_wready  out  1  block accepts s_wdata this cycle.
m_rdata  out  WORD_W  readback word; bit 0 is the first bit captured.
m_rvalid  out  1  m_rdata valid; held until m_rready.
m_rready  in  1  consumer accepts m_rdata.
config_clk  out  1  chain shift clock to the DUT.
config_in  out  1  chain serial data to the DUT.
config_load  out  1  chain parallel-load strobe to the DUT.
config_out  in  1  chain serial data from the DUT.

Behaviour:
- Reset value of all outputs is 0. Reset asserted mid-transfer: on the next edge, return to IDLE, drop config_clk/config_in/config_load/busy, and clear m_rvalid. Partial input and readback words are discarded.
- H = max(clk_half_period, 1). H is latched when start is accepted; later changes have no effect until the next start.
- States:
  - IDLE: start=1 goes to FETCH and sets busy. start is ignored in every other state.
  - FETCH: s_wready=1. When s_wvalid&s_wready, latch the word, reset the bit index to 0, and go to LO. s_wready is 0 in all other states.
  - LO: config_clk=0, config_in=current bit, held for H cycles. On the last LO cycle, sample config_out into the readback shift register; the next state is HI.
  - HI: config_clk=1, config_in unchanged, held for H cycles. Then:
    - if CHAIN_LEN bits have been sent, go to LOAD;
    - else if WORD_W bits of this word have been sent, go to FETCH;
    - else go to LO with the next bit.
  - LOAD: config_clk=0, config_in=0, config_load=1 for 2*H cycles. Then go to DRAIN.
  - DRAIN: wait until the final readback word has been accepted. Then pulse done for 1 cycle, clear busy, and go to IDLE.
- Bit count: exactly CHAIN_LEN rising edges of config_clk per transfer. The number of input words is ceil(CHAIN_LEN/WORD_W); unused high bits of the last input word are ignored.
- Readback packing: captured bits are packed LSB-first. A word is pushed to m_rdata/m_rvalid when it holds WORD_W bits, or at the CHAIN_LEN-th sample; unused high bits of a partial last word are 0.
- Backpressure: if a readback word is ready while m_rvalid=1 and m_rready=0, the FSM holds in its current state with counters frozen. config_clk stays at its present level, with no glitch, until the slot frees. m_rvalid drops the cycle after m_rvalid&m_rready unless a new word is loaded that same cycle.
- Input starvation: FETCH waits indefinitely with config_clk=0.
- Simultaneous events: start and reset together means reset wins.

Test Plan:
- Bench with CHAIN_LEN=40, WORD_W=32, H=2, and a 40-bit DUT shift-register model that shifts on config_clk rising and latches on config_load. Send words 0xDEADBEEF, 0x000000A5 → the model holds 0xA5_DEADBEEF, readback returns the prior model contents, config_clk rises exactly 40 times, and config_load is high for 4 cycles.
- Back-to-back transfers with the model preloaded to 0 → the second transfer's readback equals the first image: 0xDEADBEEF then 0x000000A5 (bits 8..31 zero).
- clk_half_period=0 then 5 → config_clk period is 2 and 10 pl_clk1 cycles respectively. Changing clk_half_period mid-transfer does not alter the period.
- Hold m_rready=0 for 50 cycles at the first readback word → config_clk freezes with no extra edges, and the transfer completes correctly after release.
- Delay s_wvalid 20 cycles before the second word → config_clk stays 0 with no extra edges, and the final image is correct.
- Assert reset during bit 17 → the next cycle has all outputs 0 and the FSM in IDLE. A following start completes a clean transfer with done pulsed once.
